muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO for the EX stage of the 5-stage core.
//  Adds MADD/MSUB accumulate, an iterative restoring divider, pipeline flush/cancel and a done pulse.
//  The stall unit holds the pipeline while busy=1 and a HI/LO-using instruction sits in ID/EX.
// PARAMETERS
//  WIDTH       32  operand width; HI and LO are each WIDTH bits
//  MUL_CYCLES   5  multiply latency L_mul in cycles (>=1)
// PORTS
//  clk    in   1      clock, rising edge
//  reset  in   1      synchronous, active-low; reset==0 at an edge clears all state
//  start  in   1      op request; sampled only when busy==0 and flush==0
//  op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
//  a      in   WIDTH  rs operand (forwarded)
//  b      in   WIDTH  rt operand (forwarded)
//  flush  in   1      cancel the in-flight op (branch/exception squash)
//  busy   out  1      op in progress
//  done   out  1      one-cycle pulse: HI/LO just updated by a mul/div/madd/msub
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset overrides start and flush.
//  FSM states: IDLE, MUL, DIV, FIX.
//   IDLE: accept start with op 000/001/100/101 -> MUL, counter=MUL_CYCLES.
//         accept start with op 010/011 -> DIV, counter=WIDTH.
//   MUL:  counter-- each cycle; at counter==1 -> IDLE and write HI/LO.
//   DIV:  one restoring step per cycle on magnitudes; after WIDTH steps -> FIX.
//   FIX:  apply signs and write HI/LO -> IDLE.
//  Operands and op are captured on the accept edge; a/b may change afterwards.
//  Timing for a start accepted in cycle t:
//   - mul class: busy=1 in t+1..t+MUL_CYCLES; new hi/lo and done=1 in t+MUL_CYCLES+1.
//   - div class: busy=1 in t+1..t+WIDTH+1; new hi/lo and done=1 in t+WIDTH+2.
//  Arithmetic:
//   - MULT/MADD/MSUB are signed; MULTU is unsigned; the product is 2*WIDTH bits.
//   - MULT/MULTU: {hi,lo}=product.
//   - MADD: {hi,lo}={hi,lo}+product, wraps mod 2^(2*WIDTH).
//   - MSUB: {hi,lo}={hi,lo}-product, wraps mod 2^(2*WIDTH).
//   - MADD/MSUB use the HI/LO value present at completion. No other op can write HI/LO while busy.
//   - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
//   - DIVU: unsigned quotient/remainder.
//   - DIV of most-negative by -1: lo=most-negative, hi=0.
//   - Divide by zero (b==0 at accept): full latency still taken and done still pulses; hi/lo unchanged.
//  MTHI/MTLO: when busy==0, hi<=a (or lo<=a) on the accept edge. Busy stays 0 and done is not pulsed.
//  start while busy==1 is ignored, including MTHI/MTLO; the pipeline must stall.
//  flush=1 while busy: abort. FSM->IDLE next edge, busy=0 next cycle, hi/lo unchanged, no done.
//  flush and start in the same cycle: flush wins and start is ignored.
//  flush during the completing cycle (t+L): the op is cancelled and hi/lo are not written.
//  Reset low mid-operation: everything returns to reset values at that edge.
//  hi/lo are only ever written on the result edge or by MTHI/MTLO; no partial values are exposed.
// TESTING (WIDTH=32, MUL_CYCLES=5)
//  1. MULT a=-3, b=5 at t -> busy t+1..t+5; t+6: hi=FFFFFFFF, lo=FFFFFFF1, done=1 for one cycle.
//  2. MTHI a=0, MTLO a=10, then MADD a=4, b=6 -> hi=0, lo=34. Then MSUB a=-1, b=2 -> lo=36.
//  3. DIVU 100/7 at t -> busy t+1..t+33; t+34: lo=14, hi=2.
//     DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  4. hi/lo=1234/5678, DIV x/0 -> done at t+34; hi=1234, lo=5678 unchanged.
//  5. DIVU started, flush at t+10 -> busy=0 at t+11, no done, hi/lo unchanged. Start with flush=1 -> busy stays 0.
//  6. MULT started, reset=0 at t+3 -> hi=lo=0, busy=0. A start/MTHI issued while busy -> ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply/divide unit with HI/LO, MADD/MSUB,
//                restoring divider, flush/cancel and a completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MADD  = 3'b100;
    localparam logic [2:0] c_OP_MSUB  = 3'b101;
    localparam logic [2:0] c_OP_MTHI  = 3'b110;
    localparam logic [2:0] c_OP_MTLO  = 3'b111;

    localparam int c_CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state, w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a, r_b, r_rem, r_quo, r_hi, r_lo;
    logic                 r_neg_q, r_neg_r, r_dvz, r_done;
    logic                 w_commit, w_accept, w_op_mul, w_op_div;

    assign w_accept = start && !flush && (r_state == S_IDLE);
    assign w_op_mul = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                      (op == c_OP_MADD) || (op == c_OP_MSUB);
    assign w_op_div = (op == c_OP_DIV) || (op == c_OP_DIVU);

    // Divider works on magnitudes; signs are restored in FIX
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    assign w_a_neg = (op == c_OP_DIV) && a[WIDTH-1];
    assign w_b_neg = (op == c_OP_DIV) && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    logic [WIDTH:0]   w_shift, w_diff;
    logic             w_ge;
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = !w_diff[WIDTH];

    logic [WIDTH-1:0] w_q_fin, w_r_fin;
    assign w_q_fin = r_neg_q ? -r_quo : r_quo;
    assign w_r_fin = r_neg_r ? -r_rem : r_rem;

    // Product evaluated once at completion from the captured operands
    logic                      w_mul_sgn;
    logic signed [2*WIDTH+1:0] w_ma_x, w_mb_x, w_prod;
    logic [2*WIDTH-1:0]        w_acc, w_mul_res;
    assign w_mul_sgn = (r_op != c_OP_MULTU);
    assign w_ma_x    = {{(WIDTH+2){w_mul_sgn & r_a[WIDTH-1]}}, r_a};
    assign w_mb_x    = {{(WIDTH+2){w_mul_sgn & r_b[WIDTH-1]}}, r_b};
    assign w_prod    = w_ma_x * w_mb_x;
    assign w_acc     = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod[2*WIDTH-1:0];
        if (r_op == c_OP_MADD)
            w_mul_res = w_acc + w_prod[2*WIDTH-1:0];
        else if (r_op == c_OP_MSUB)
            w_mul_res = w_acc - w_prod[2*WIDTH-1:0];
    end

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_op_mul)
                    w_next = S_MUL;
                else if (w_accept && w_op_div)
                    w_next = S_DIV;
            end
            S_MUL: begin
                if (flush)
                    w_next = S_IDLE;
                else if (r_cnt == c_CNT_ONE) begin
                    w_next   = S_IDLE;
                    w_commit = 1'b1;
                end
            end
            S_DIV: begin
                if (flush)
                    w_next = S_IDLE;
                else if (r_cnt == c_CNT_ONE)
                    w_next = S_FIX;
            end
            S_FIX: begin
                w_next   = S_IDLE;
                w_commit = !flush;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvz   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_commit;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_dvz <= (b == '0);
                        if (w_op_mul) begin
                            r_a   <= a;
                            r_b   <= b;
                            r_cnt <= c_CNT_W'(MUL_CYCLES);
                        end else if (w_op_div) begin
                            r_b     <= w_b_mag;
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= c_CNT_W'(WIDTH);
                        end else if (op == c_OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == c_OP_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (w_commit)
                        {r_hi, r_lo} <= w_mul_res;
                end
                S_DIV: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                end
                S_FIX: begin
                    if (w_commit && !r_dvz)
                        {r_hi, r_lo} <= {w_r_fin, w_q_fin};
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit (WIDTH=32, MUL_CYCLES=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int c_W    = 32;
    localparam int c_LMUL = 5;
    localparam int c_LDIV = c_W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [c_W-1:0] a = '0, b = '0;
    logic          flush = 1'b0;
    logic          busy, done;
    logic [c_W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(c_W), .MUL_CYCLES(c_LMUL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t_acc = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sx, sy;
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        up = {32'b0, x} * {32'b0, y};
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (y == 0) return acc;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            3'd3: begin
                if (y == 0) return acc;
                return {x % y, x / y};
            end
            3'd4: return acc + sp;
            3'd5: return acc - sp;
            3'd6: return {x, acc[31:0]};
            default: return {acc[63:32], x};
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0)
                chk("spurious_done", 64'd1, 64'd0);
            else
                chk("sb_hilo", {hi, lo}, sb_q.pop_front());
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit keep);
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        t_acc = cyc;
        start = 1'b0; a = $urandom; b = $urandom;
        if (keep) begin
            e = model(o, x, y, {m_hi, m_lo});
            {m_hi, m_lo} = e;
            if (o <= 3'd5) sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag, input int lat);
        int got;
        bit bad;
        got = -1;
        bad = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                got = cyc - t_acc;
                break;
            end
            if (!busy) bad = 1'b1;
        end
        chk({tag, "_lat"}, 64'(got), 64'(lat));
        chk({tag, "_busy"}, 64'(bad), 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        issue(o, x, y, 1'b1);
        if (o <= 3'd5) begin
            wait_done(tag, (o == 3'd2 || o == 3'd3) ? c_LDIV : c_LMUL);
        end else begin
            @(negedge clk);
            chk({tag, "_mt"}, {30'd0, busy, done, hi, lo}, {30'd0, 2'b00, m_hi, m_lo});
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {30'd0, busy, done, hi, lo}, 64'd0);
        reset = 1'b1;

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5);
        chk("mult_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        run_op("mthi", 3'd6, 32'd0, 32'd0);
        run_op("mtlo", 3'd7, 32'd10, 32'd0);
        run_op("madd", 3'd4, 32'd4, 32'd6);
        chk("madd_val", {hi, lo}, {32'd0, 32'd34});
        run_op("msub", 3'd5, 32'hFFFF_FFFF, 32'd2);
        chk("msub_val", {hi, lo}, {32'd0, 32'd36});

        run_op("divu", 3'd3, 32'd100, 32'd7);
        chk("divu_val", {hi, lo}, {32'd2, 32'd14});
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_val", {hi, lo}, {32'd0, 32'h8000_0000});

        run_op("mthi2", 3'd6, 32'd1234, 32'd0);
        run_op("mtlo2", 3'd7, 32'd5678, 32'd0);
        run_op("div0", 3'd2, 32'd99, 32'd0);
        chk("div0_val", {hi, lo}, {32'd1234, 32'd5678});

        // Flush in the middle of a divide
        issue(3'd3, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush in the completing multiply cycle
        issue(3'd0, 32'd77, 32'd88, 1'b0);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flushL_state", {31'd0, busy, done, 31'd0}, 64'd0);
        repeat (3) @(negedge clk);
        chk("flushL_hilo", {hi, lo}, {m_hi, m_lo});

        // start together with flush is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd6; a = 32'hBEEF;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("sf_busy", 64'(busy), 64'd0);
        chk("sf_hilo", {hi, lo}, {m_hi, m_lo});

        // start/MTHI while busy is ignored
        issue(3'd0, 32'd7, 32'd9, 1'b1);
        start = 1'b1; op = 3'd6; a = 32'hDEAD;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ign", c_LMUL);
        chk("ign_val", {hi, lo}, 64'd63);

        // Reset low mid-multiply
        issue(3'd0, 32'd11, 32'd13, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        chk("rst_mid", {30'd0, busy, done, hi, lo}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            logic [2:0]  ro;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op("rnd", ro, $urandom, rb);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
